// File: rtl/mem_pkg.sv
// Shared constants, types and the bank-select helper for the four-bank memory responder.
package mem_pkg;

    localparam int NUM_BANKS       = 4;
    localparam int BANK_SEL_LSB    = 1;
    localparam int BANK_SEL_MSB    = 2;
    localparam int WORD_SEL_LSB    = 3;
    localparam int BUSY_CYCLES_DEF = 4;
    localparam int RD_LAT_DEF      = 2;

    typedef logic [BANK_SEL_MSB-BANK_SEL_LSB:0] bank_idx_t;

    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_RD   = 2'd1,
        REQ_WR   = 2'd2
    } req_kind_e;

    function automatic bank_idx_t bank_of(input logic [BANK_SEL_MSB:BANK_SEL_LSB] sel_bits);
        return bank_idx_t'(sel_bits);
    endfunction

endpackage

// File: rtl/mem_bank.sv
// One memory bank: storage array, synchronous read register and occupancy down-counter.
// Storage is deliberately not reset so contents survive a reset pulse.
module mem_bank #(
    parameter int DATA_W      = 16,
    parameter int BANK_WORDS  = 512,
    parameter int BUSY_CYCLES = 4,
    parameter int WORD_W      = $clog2(BANK_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              acc_i,
    input  logic              we_i,
    input  logic [WORD_W-1:0] word_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              busy_o
);

    localparam int CNT_W = $clog2(BUSY_CYCLES);

    logic [DATA_W-1:0] mem_q [BANK_WORDS];
    logic [DATA_W-1:0] rdata_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    always_ff @(posedge clk) begin
        if (acc_i && we_i) begin
            mem_q[word_i] <= wdata_i;
        end
        if (acc_i && !we_i) begin
            rdata_q <= mem_q[word_i];
        end
    end

    // Loading BUSY_CYCLES-1 keeps the bank busy for the cycles after acceptance only.
    always_comb begin
        cnt_d = cnt_q;
        if (acc_i) begin
            cnt_d = CNT_W'(BUSY_CYCLES - 1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_o  = (cnt_q != '0);
    assign rdata_o = rdata_q;

endmodule

// File: rtl/four_bank_mem_resp.sv
// Four-bank word-interleaved memory responder: request decode, stall/err and read return pipe.
// Optional request checking is enabled by defining MEM_ERR_CHECK_EN.
module four_bank_mem_resp
    import mem_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int BANK_WORDS  = 512,
    parameter int BUSY_CYCLES = BUSY_CYCLES_DEF,
    parameter int RD_LAT      = RD_LAT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rd,
    input  logic                 wr,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [DATA_W-1:0]    data_in,
    output logic [DATA_W-1:0]    data_out,
    output logic                 data_valid,
    output logic                 stall,
    output logic [NUM_BANKS-1:0] busy,
    output logic                 err
);

    localparam int WORD_W = $clog2(BANK_WORDS);

    logic        req;
    logic        acc;
    bank_idx_t   bank;
    req_kind_e   req_kind;
    logic [WORD_W-1:0] word;

    assign req  = rd | wr;
    assign bank = bank_of(addr[BANK_SEL_MSB:BANK_SEL_LSB]);
    assign word = addr[WORD_SEL_LSB +: WORD_W];

    // A simultaneous rd/wr resolves to a write when it is not flagged as an error.
    always_comb begin
        req_kind = REQ_NONE;
        if (wr) begin
            req_kind = REQ_WR;
        end else if (rd) begin
            req_kind = REQ_RD;
        end
    end

`ifdef MEM_ERR_CHECK_EN
    logic word_oob;
    assign word_oob = |addr[ADDR_W-1:WORD_SEL_LSB+WORD_W];
    assign err      = req & (addr[0] | (rd & wr) | word_oob);
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr[0], addr[ADDR_W-1:WORD_SEL_LSB+WORD_W]};
    assign err              = 1'b0;
`endif

    // An erroring request is dropped outright, so it never reports a stall.
    assign acc   = req & ~busy[bank] & ~err;
    assign stall = req &  busy[bank] & ~err;

    logic [DATA_W-1:0] bank_rdata [NUM_BANKS];

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        mem_bank #(
            .DATA_W      (DATA_W),
            .BANK_WORDS  (BANK_WORDS),
            .BUSY_CYCLES (BUSY_CYCLES),
            .WORD_W      (WORD_W)
        ) u_bank (
            .clk     (clk),
            .rst     (rst),
            .acc_i   (acc && (bank == bank_idx_t'(g))),
            .we_i    (req_kind == REQ_WR),
            .word_i  (word),
            .wdata_i (data_in),
            .rdata_o (bank_rdata[g]),
            .busy_o  (busy[g])
        );
    end

    // Stage 1 is the bank's own read register; the remaining RD_LAT-1 stages live here.
    logic              s1_valid_q;
    bank_idx_t         s1_bank_q;
    logic              ret_valid_q [RD_LAT-1];
    logic [DATA_W-1:0] ret_data_q  [RD_LAT-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_bank_q  <= '0;
            for (int i = 0; i < RD_LAT-1; i++) begin
                ret_valid_q[i] <= 1'b0;
                ret_data_q[i]  <= '0;
            end
        end else begin
            s1_valid_q     <= acc & (req_kind == REQ_RD);
            s1_bank_q      <= bank;
            ret_valid_q[0] <= s1_valid_q;
            ret_data_q[0]  <= bank_rdata[s1_bank_q];
            for (int i = RD_LAT-2; i > 0; i--) begin
                ret_valid_q[i] <= ret_valid_q[i-1];
                ret_data_q[i]  <= ret_data_q[i-1];
            end
        end
    end

    assign data_valid = ret_valid_q[RD_LAT-2];
    assign data_out   = ret_valid_q[RD_LAT-2] ? ret_data_q[RD_LAT-2] : '0;

endmodule

// File: doc/four_bank_mem_resp.md
# four_bank_mem_resp

Responder side of the cache-to-memory interface: a four-bank, word-interleaved main memory that accepts one read or write request per cycle from the cache controller. Each accepted request occupies its bank for four cycles, reported on `busy`. Read data returns a fixed two cycles after acceptance. A request that targets a busy bank is refused with `stall`, and the controller re-presents it.

## Interface
- `DATA_W`, 16, data word width in bits
- `ADDR_W`, 16, byte-address width
- `BANK_WORDS`, 512, words per bank (total 4×512 words)
- `BUSY_CYCLES`, 4, cycles a bank is occupied per accepted request, counting the acceptance cycle
- `RD_LAT`, 2, clock edges from acceptance to read data
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `rd`  in  1  read request
- `wr`  in  1  write request
- `addr`  in  ADDR_W  byte address; `addr[2:1]` selects the bank, `addr[ADDR_W-1:3]` selects the word within the bank
- `data_in`  in  DATA_W  write data
- `data_out`  out  DATA_W  read data; valid only while `data_valid` is 1, otherwise 0
- `data_valid`  out  1  one-cycle pulse marking returned read data
- `stall`  out  1  combinational; request present this cycle but not accepted
- `busy`  out  4  per-bank occupancy, one bit per bank
- `err`  out  1  combinational; illegal request this cycle (see Configuration)

## Operation
- Request present: `rd | wr`. Target bank `b = addr[2:1]`.
- Accept condition: request present, `busy[b] == 0`, and no error. `stall = request & busy[b]`. An erroring request is dropped without stalling.
- Accepted write: `mem[b][word] <= data_in` at the acceptance edge.
- Accepted read: the word is captured and travels down an `RD_LAT`-deep return pipe tagged valid.
- Up to four requests may be in flight at once, one per bank. Back-to-back reads to different banks return back to back, in issue order.
- Per-bank down-counter: loads `BUSY_CYCLES-1` on acceptance, decrements to 0. `busy[b] = (count_b != 0)`.
- Same-bank reuse is blocked by `busy`, so read-after-write to one bank always sees the written data.
- No state machine beyond the four bank counters and the return pipe. Counter width is `$clog2(BUSY_CYCLES)`.
- Word index wraps modulo `BANK_WORDS`; address bits above that are ignored unless `MEM_ERR_CHECK_EN` is defined.

## Timing
- Reset values: `busy=0`, `data_valid=0`, `data_out=0`. `stall` and `err` are 0 while no request is present.
- Reset mid-operation:
  - counters cleared
  - return pipe flushed, so no `data_valid` is produced for in-flight reads
  - memory contents retained
- Request accepted in cycle t:
  - `busy[b]` is 1 in cycles t+1 through t+BUSY_CYCLES-1
  - the bank can accept again in cycle t+BUSY_CYCLES
- Read accepted in cycle t: `data_valid=1` and `data_out` valid in cycle t+RD_LAT, for exactly one cycle.
- A request to bank b in the cycle its counter reaches 0 (`busy[b]=0`) is accepted.
- The requester must hold `rd`/`wr`/`addr`/`data_in` stable while `stall=1`; the block keeps no request buffer.

## Configuration
- `MEM_ERR_CHECK_EN` defined: `err=1` and the request is dropped when any of these holds:
  - `addr[0]==1` (unaligned)
  - `rd & wr`
  - word index ≥ `BANK_WORDS`
  
  `err` takes priority over `stall`.
- Not defined: `err` is tied to 0 and `addr[0]` is ignored. With `rd & wr` only the write is performed. Out-of-range addresses wrap.

## Structure
- Package `mem_pkg`:
  - `NUM_BANKS=4`
  - bank-select bit positions
  - `BUSY_CYCLES` and `RD_LAT` defaults
  - a bank-index function from `addr`
- Sub-module `mem_bank`: one bank's storage array, busy counter, and synchronous read port. Instantiated four times by a generate loop. The top level holds request decode, `stall`/`err` logic and the return pipe.

## Test plan
- Write 0xBEEF to addr 0x0010 (bank 0), wait 4 cycles, read 0x0010 → `data_valid` and `data_out=0xBEEF` exactly 2 cycles after read acceptance. `busy[0]` is high for 3 cycles after each access.
- Reads in consecutive cycles to 0x0000, 0x0002, 0x0004, 0x0006 (banks 0–3) → all accepted, `stall` never 1, four consecutive `data_valid` pulses returning the four preloaded words in order.
- Write 0x1234 then read the same bank one cycle later (0x0008 then 0x0000) → `stall=1` for 3 cycles, the read is accepted in cycle t+4 and returns the correct word.
- Read 0x0012 accepted, `rst` pulsed the following cycle → no `data_valid`, `busy=0` immediately, and a later read of 0x0012 returns the pre-reset contents.
- With `MEM_ERR_CHECK_EN`: read 0x0011 → `err=1`, `stall=0`, `busy` unchanged, no `data_valid`. `rd=wr=1` at 0x0020 → `err=1` and memory is unchanged.
- Without `MEM_ERR_CHECK_EN`: `rd=wr=1`, addr 0x0020, data 0x5555 → the write is performed, no `data_valid`, and a later read of 0x0020 returns 0x5555.
